// File: rtl/yarvi_mq_pkg.sv
// Shared definitions for the memory request queue: datapath widths and the
// bit layout of one packed queue entry (LSB first).
package yarvi_mq_pkg;

  localparam int VMSB     = 31;
  localparam int XMSB     = 31;
  localparam int SIZEW    = 2;
  localparam int OFF_SEXT = 0;
  localparam int OFF_TAG  = 1;

  function automatic int off_size(input int tagw);
    return OFF_TAG + tagw;
  endfunction

  function automatic int off_wdata(input int tagw);
    return off_size(tagw) + SIZEW;
  endfunction

  function automatic int off_addr(input int tagw);
    return off_wdata(tagw) + XMSB + 1;
  endfunction

  function automatic int off_we(input int tagw);
    return off_addr(tagw) + VMSB + 1;
  endfunction

  // 1 + (VMSB+1) + (XMSB+1) + 2 + TAGW + 1
  function automatic int mq_entry_w(input int tagw);
    return off_we(tagw) + 1;
  endfunction

endpackage

// File: rtl/yarvi_mq_if.sv
// Execute-to-memory request bundle: request inputs, queue head outputs,
// memory-side ready and occupancy status.
interface yarvi_mq_if
  import yarvi_mq_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int TAGW  = 5
);
  logic                       valid;
  logic                       writeenable;
  logic [VMSB:0]              address;
  logic [XMSB:0]              writedata;
  logic [SIZEW-1:0]           sizelg2;
  logic [TAGW-1:0]            readtag;
  logic                       readsignextend;
  logic                       mq_ready;

  logic                       mq_valid;
  logic                       mq_writeenable;
  logic [VMSB:0]              mq_address;
  logic [XMSB:0]              mq_writedata;
  logic [SIZEW-1:0]           mq_sizelg2;
  logic [TAGW-1:0]            mq_readtag;
  logic                       mq_readsignextend;
  logic                       me_ready;

  logic [$clog2(DEPTH):0]     mq_count;
  logic                       mq_drained;

  modport master (
    output valid, writeenable, address, writedata, sizelg2, readtag,
           readsignextend, me_ready,
    input  mq_ready, mq_valid, mq_writeenable, mq_address, mq_writedata,
           mq_sizelg2, mq_readtag, mq_readsignextend, mq_count, mq_drained
  );

  modport slave (
    input  valid, writeenable, address, writedata, sizelg2, readtag,
           readsignextend, me_ready,
    output mq_ready, mq_valid, mq_writeenable, mq_address, mq_writedata,
           mq_sizelg2, mq_readtag, mq_readsignextend, mq_count, mq_drained
  );

endinterface

// File: rtl/yarvi_fifo.sv
// Generic in-order FIFO: zero-reset storage, wrapping head/tail pointers and
// an explicit occupancy count that separates full from empty.
module yarvi_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clock,
  input  logic                     reset_n,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rdata,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    head;
  logic [PW-1:0]    tail;
  logic             do_push;
  logic             do_pop;

  // Pushes into a full queue are dropped even when a pop happens the same cycle.
  assign do_push = push && (count != CW'(DEPTH));
  assign do_pop  = pop  && (count != '0);
  assign rdata   = mem[head];

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (do_push) begin
        mem[tail] <= wdata;
        tail      <= tail + PW'(1);
      end
      if (do_pop) head <= head + PW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/yarvi_mq.sv
// Memory request queue between execute and memory: packs requests into FIFO
// entries, unpacks the head and derives the valid/ready/drain outputs.
module yarvi_mq
  import yarvi_mq_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int TAGW  = 5
) (
  input  logic       clock,
  input  logic       reset_n,
  yarvi_mq_if.slave  mq
);

  localparam int W  = mq_entry_w(TAGW);
  localparam int CW = $clog2(DEPTH) + 1;

  logic [W-1:0]  wdata;
  logic [W-1:0]  rdata;
  logic [CW-1:0] count;
  logic          full;
  logic          push;
  logic          pop;

  assign full          = (count == CW'(DEPTH));
  assign mq.mq_ready   = reset_n && !full;
  assign mq.mq_valid   = (count != '0);
  assign mq.mq_drained = (count == '0);
  assign mq.mq_count   = count;

  assign push = mq.valid && mq.mq_ready;
  assign pop  = mq.mq_valid && mq.me_ready;

  always_comb begin
    wdata                            = '0;
    wdata[OFF_SEXT]                  = mq.readsignextend;
    wdata[OFF_TAG +: TAGW]           = mq.readtag;
    wdata[off_size(TAGW) +: SIZEW]   = mq.sizelg2;
    wdata[off_wdata(TAGW) +: XMSB+1] = mq.writedata;
    wdata[off_addr(TAGW) +: VMSB+1]  = mq.address;
    wdata[off_we(TAGW)]              = mq.writeenable;
  end

  assign mq.mq_readsignextend = rdata[OFF_SEXT];
  assign mq.mq_readtag        = rdata[OFF_TAG +: TAGW];
  assign mq.mq_sizelg2        = rdata[off_size(TAGW) +: SIZEW];
  assign mq.mq_writedata      = rdata[off_wdata(TAGW) +: XMSB+1];
  assign mq.mq_address        = rdata[off_addr(TAGW) +: VMSB+1];
  assign mq.mq_writeenable    = rdata[off_we(TAGW)];

  yarvi_fifo #(
    .WIDTH (W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clock   (clock),
    .reset_n (reset_n),
    .push    (push),
    .wdata   (wdata),
    .pop     (pop),
    .rdata   (rdata),
    .count   (count)
  );

  // Execute must never offer a request to a full queue; such a request is lost.
  push_while_full: assert property (@(posedge clock) disable iff (!reset_n)
    !(mq.valid && full))
    else $warning("yarvi_mq: request dropped, queue full");

endmodule
